// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer for the ralu datapath.
// Each instruction is fetched from the synchronous program ROM, then decoded,
// then executed. Branches and jumps use the RALU zero flag. WAITV locks the
// program to the video frame by stalling until the next vsync tick.
module control_unit #(
   parameter int         PC_WIDTH = 10,
   parameter logic [3:0] ALU_ADD  = 4'h0,
   parameter logic [3:0] ALU_SUB  = 4'h1
) (
   input  logic                sys_clock,
   input  logic                sys_rst_n,
   output logic [PC_WIDTH-1:0] instr_addr,
   input  logic [31:0]         instr_data,
   input  logic                vsync_tick,
   input  logic                zero_flag,
   input  logic [15:0]         result,
   input  logic [15:0]         operand1,
   output logic [3:0]          addr_operand0,
   output logic [3:0]          addr_operand1,
   output logic [3:0]          addr_result,
   output logic [15:0]         instr_value,
   output logic [3:0]          alu_op_sel,
   output logic                alu_src,
   output logic [1:0]          reg_write_src,
   output logic                w_en,
   output logic [15:0]         data_mem_addr,
   output logic [15:0]         data_mem_wdata,
   output logic                data_mem_we,
   output logic                halted,
   output logic                illegal_instr
);

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_ALUR  = 4'd1;
   localparam logic [3:0] OP_ALUI  = 4'd2;
   localparam logic [3:0] OP_LOAD  = 4'd3;
   localparam logic [3:0] OP_STORE = 4'd4;
   localparam logic [3:0] OP_RAND  = 4'd5;
   localparam logic [3:0] OP_BEQ   = 4'd6;
   localparam logic [3:0] OP_BNE   = 4'd7;
   localparam logic [3:0] OP_JMP   = 4'd8;
   localparam logic [3:0] OP_WAITV = 4'd9;
   localparam logic [3:0] OP_HALT  = 4'd15;

   localparam logic [1:0] SRC_ALU  = 2'b00;
   localparam logic [1:0] SRC_MEM  = 2'b01;
   localparam logic [1:0] SRC_RAND = 2'b10;

   localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXECUTE,
      LOAD_WB,
      WAIT_VS,
      HALT_ST
   } state_t;

   state_t              state;
   logic [PC_WIDTH-1:0] pc;
   logic [31:0]         ir;

   logic [3:0]  opcode;
   logic [3:0]  ir_alu_op;
   logic [3:0]  ir_rd;
   logic [3:0]  ir_rs0;
   logic [15:0] ir_imm;
   logic        branch_taken;
   logic        is_illegal;

   assign opcode    = ir[31:28];
   assign ir_alu_op = ir[27:24];
   assign ir_rd     = ir[23:20];
   assign ir_rs0    = ir[19:16];
   assign ir_imm    = ir[15:0];

   // Opcodes 10..14 are undefined and run as a NOP that raises illegal_instr.
   assign is_illegal = (opcode >= 4'd10) && (opcode <= 4'd14);

   assign branch_taken = (opcode == OP_JMP) ||
                         ((opcode == OP_BEQ) &&  zero_flag) ||
                         ((opcode == OP_BNE) && !zero_flag);

   assign instr_addr     = pc;
   assign data_mem_addr  = result;
   assign data_mem_wdata = operand1;

   // Sequencer: steps FETCH/DECODE/EXECUTE, latches IR, advances pc and resolves branches.
   always_ff @(posedge sys_clock or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= FETCH;
         pc    <= '0;
         ir    <= '0;
      end else begin
         case (state)
            FETCH: begin
               state <= DECODE;
            end
            DECODE: begin
               ir    <= instr_data;
               pc    <= pc + PC_ONE;
               state <= EXECUTE;
            end
            EXECUTE: begin
               if (branch_taken) begin
                  pc <= ir_imm[PC_WIDTH-1:0];
               end
               case (opcode)
                  OP_LOAD:  state <= LOAD_WB;
                  OP_WAITV: state <= WAIT_VS;
                  OP_HALT:  state <= HALT_ST;
                  default:  state <= FETCH;
               endcase
            end
            LOAD_WB: begin
               state <= FETCH;
            end
            WAIT_VS: begin
               if (vsync_tick) begin
                  state <= FETCH;
               end
            end
            HALT_ST: begin
               state <= HALT_ST;
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

   // Decoded datapath controls and write strobes, derived from IR and the current state.
   always_comb begin
      addr_result   = ir_rd;
      addr_operand0 = ir_rs0;
      instr_value   = ir_imm;
      addr_operand1 = ir_imm[3:0];
      alu_op_sel    = ir_alu_op;
      alu_src       = 1'b0;
      reg_write_src = SRC_ALU;
      w_en          = 1'b0;
      data_mem_we   = 1'b0;
      halted        = (state == HALT_ST);
      illegal_instr = 1'b0;

      case (opcode)
         OP_ALUI: begin
            alu_src = 1'b1;
         end
         OP_LOAD: begin
            alu_op_sel = ALU_ADD;
            alu_src    = 1'b1;
         end
         OP_STORE: begin
            alu_op_sel    = ALU_ADD;
            alu_src       = 1'b1;
            addr_operand1 = ir_rd;
         end
         OP_BEQ, OP_BNE: begin
            alu_op_sel    = ALU_SUB;
            addr_operand1 = ir_rd;
         end
         default: begin
         end
      endcase

      if (state == EXECUTE) begin
         case (opcode)
            OP_ALUR, OP_ALUI: begin
               w_en = 1'b1;
            end
            OP_RAND: begin
               w_en          = 1'b1;
               reg_write_src = SRC_RAND;
            end
            OP_STORE: begin
               data_mem_we = 1'b1;
            end
            default: begin
               illegal_instr = is_illegal;
            end
         endcase
      end else if (state == LOAD_WB) begin
         w_en          = 1'b1;
         reg_write_src = SRC_MEM;
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit.
// Each instruction placed in the ROM model pushes one expected record per
// clock cycle it should take; the run loop drives that cycle's inputs,
// pops the record and compares the DUT outputs against it.
module tb_control_unit;

   localparam int          PW           = 10;
   localparam logic [15:0] RESULT_VAL   = 16'h0020;
   localparam logic [15:0] OPERAND1_VAL = 16'hBEEF;

   logic          sys_clock;
   logic          sys_rst_n;
   logic [PW-1:0] instr_addr;
   logic [31:0]   instr_data;
   logic          vsync_tick;
   logic          zero_flag;
   logic [15:0]   result;
   logic [15:0]   operand1;
   logic [3:0]    addr_operand0;
   logic [3:0]    addr_operand1;
   logic [3:0]    addr_result;
   logic [15:0]   instr_value;
   logic [3:0]    alu_op_sel;
   logic          alu_src;
   logic [1:0]    reg_write_src;
   logic          w_en;
   logic [15:0]   data_mem_addr;
   logic [15:0]   data_mem_wdata;
   logic          data_mem_we;
   logic          halted;
   logic          illegal_instr;

   typedef struct {
      logic          tick;
      logic          zf;
      logic [PW-1:0] iaddr;
      logic          wen;
      logic          mwe;
      logic [1:0]    wsrc;
      logic          ill;
      logic          hlt;
      logic          chkDec;
      logic [3:0]    ares;
      logic [3:0]    aop0;
      logic [3:0]    aop1;
      logic [3:0]    alu;
      logic          asrc;
      logic [15:0]   imm;
      logic          chkMem;
   } cycleExp_t;

   cycleExp_t     expQ[$];
   logic [31:0]   rom [0:(1<<PW)-1];
   logic [PW-1:0] tbPc;
   int            totalCount;
   int            badCount;

   control_unit #(
      .PC_WIDTH (PW),
      .ALU_ADD  (4'h0),
      .ALU_SUB  (4'h1)
   ) dut (
      .sys_clock      (sys_clock),
      .sys_rst_n      (sys_rst_n),
      .instr_addr     (instr_addr),
      .instr_data     (instr_data),
      .vsync_tick     (vsync_tick),
      .zero_flag      (zero_flag),
      .result         (result),
      .operand1       (operand1),
      .addr_operand0  (addr_operand0),
      .addr_operand1  (addr_operand1),
      .addr_result    (addr_result),
      .instr_value    (instr_value),
      .alu_op_sel     (alu_op_sel),
      .alu_src        (alu_src),
      .reg_write_src  (reg_write_src),
      .w_en           (w_en),
      .data_mem_addr  (data_mem_addr),
      .data_mem_wdata (data_mem_wdata),
      .data_mem_we    (data_mem_we),
      .halted         (halted),
      .illegal_instr  (illegal_instr)
   );

   // Free-running 100 MHz system clock.
   initial sys_clock = 1'b0;
   always #5 sys_clock = ~sys_clock;

   // Synchronous program ROM: data appears one cycle after the address.
   always @(posedge sys_clock) begin
      instr_data <= rom[instr_addr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalCount++;
      if (observed !== expected) begin
         badCount++;
         $display("[TB] FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, observed, expected);
      end
   endtask

   function automatic logic [31:0] mkInstr(input logic [3:0] op, input logic [3:0] aluOp,
                                           input logic [3:0] rd, input logic [3:0] rs0,
                                           input logic [15:0] imm);
      return {op, aluOp, rd, rs0, imm};
   endfunction

   // Places one instruction at the tracked pc and queues the cycles it should produce.
   task automatic applyStimulus(input logic [31:0] instr, input logic zf, input logic tickInExec,
                                input int waitLen, input int haltLen);
      logic [3:0]    op;
      logic [3:0]    aluOp;
      logic [3:0]    rd;
      logic [3:0]    rs0;
      logic [15:0]   imm;
      logic [PW-1:0] nxt;
      logic          taken;
      cycleExp_t     e;
      op    = instr[31:28];
      aluOp = instr[27:24];
      rd    = instr[23:20];
      rs0   = instr[19:16];
      imm   = instr[15:0];
      nxt   = tbPc + 10'd1;
      rom[tbPc] = instr;

      e = '{default: '0};
      e.iaddr = tbPc;
      expQ.push_back(e);
      expQ.push_back(e);

      e = '{default: '0};
      e.iaddr  = nxt;
      e.zf     = zf;
      e.tick   = tickInExec;
      e.wen    = (op == 4'd1) || (op == 4'd2) || (op == 4'd5);
      e.mwe    = (op == 4'd4);
      e.wsrc   = (op == 4'd5) ? 2'b10 : 2'b00;
      e.ill    = (op >= 4'd10) && (op <= 4'd14);
      e.chkDec = 1'b1;
      e.ares   = rd;
      e.aop0   = rs0;
      e.aop1   = ((op == 4'd4) || (op == 4'd6) || (op == 4'd7)) ? rd : imm[3:0];
      e.asrc   = (op == 4'd2) || (op == 4'd3) || (op == 4'd4);
      e.alu    = ((op == 4'd3) || (op == 4'd4)) ? 4'h0 :
                 ((op == 4'd6) || (op == 4'd7)) ? 4'h1 : aluOp;
      e.imm    = imm;
      e.chkMem = (op == 4'd4);
      expQ.push_back(e);

      if (op == 4'd3) begin
         e.tick = 1'b0;
         e.wen  = 1'b1;
         e.wsrc = 2'b01;
         expQ.push_back(e);
      end
      if (op == 4'd9) begin
         for (int i = 0; i < waitLen; i++) begin
            e = '{default: '0};
            e.iaddr = nxt;
            e.tick  = (i == waitLen - 1);
            expQ.push_back(e);
         end
      end
      if (op == 4'd15) begin
         for (int i = 0; i < haltLen; i++) begin
            e = '{default: '0};
            e.iaddr = nxt;
            e.hlt   = 1'b1;
            e.tick  = i[0];
            expQ.push_back(e);
         end
      end

      taken = (op == 4'd8) || ((op == 4'd6) && zf) || ((op == 4'd7) && !zf);
      tbPc  = taken ? imm[PW-1:0] : nxt;
   endtask

   // Pops up to n queued cycles, driving their inputs and checking the outputs mid-cycle.
   task automatic runCycles(input int n);
      cycleExp_t e;
      int        k;
      k = 0;
      while ((expQ.size() > 0) && (k < n)) begin
         e = expQ.pop_front();
         zero_flag  = e.zf;
         vsync_tick = e.tick;
         @(negedge sys_clock);
         checkOutput("instr_addr", 32'(instr_addr), 32'(e.iaddr));
         checkOutput("w_en", 32'(w_en), 32'(e.wen));
         checkOutput("data_mem_we", 32'(data_mem_we), 32'(e.mwe));
         checkOutput("reg_write_src", 32'(reg_write_src), 32'(e.wsrc));
         checkOutput("illegal_instr", 32'(illegal_instr), 32'(e.ill));
         checkOutput("halted", 32'(halted), 32'(e.hlt));
         if (e.chkDec) begin
            checkOutput("addr_result", 32'(addr_result), 32'(e.ares));
            checkOutput("addr_operand0", 32'(addr_operand0), 32'(e.aop0));
            checkOutput("addr_operand1", 32'(addr_operand1), 32'(e.aop1));
            checkOutput("alu_op_sel", 32'(alu_op_sel), 32'(e.alu));
            checkOutput("alu_src", 32'(alu_src), 32'(e.asrc));
            checkOutput("instr_value", 32'(instr_value), 32'(e.imm));
         end
         if (e.chkMem) begin
            checkOutput("data_mem_addr", 32'(data_mem_addr), 32'(RESULT_VAL));
            checkOutput("data_mem_wdata", 32'(data_mem_wdata), 32'(OPERAND1_VAL));
         end
         @(posedge sys_clock);
         #1;
         k++;
      end
   endtask

   task automatic doInstr(input logic [31:0] instr, input logic zf, input logic tickInExec,
                          input int waitLen, input int haltLen);
      applyStimulus(instr, zf, tickInExec, waitLen, haltLen);
      runCycles(1000);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_instr_addr"}, 32'(instr_addr), 32'd0);
      checkOutput({tag, "_w_en"}, 32'(w_en), 32'd0);
      checkOutput({tag, "_data_mem_we"}, 32'(data_mem_we), 32'd0);
      checkOutput({tag, "_halted"}, 32'(halted), 32'd0);
      checkOutput({tag, "_illegal"}, 32'(illegal_instr), 32'd0);
      checkOutput({tag, "_addr_result"}, 32'(addr_result), 32'd0);
      checkOutput({tag, "_addr_operand0"}, 32'(addr_operand0), 32'd0);
      checkOutput({tag, "_addr_operand1"}, 32'(addr_operand1), 32'd0);
      checkOutput({tag, "_alu_src"}, 32'(alu_src), 32'd0);
      checkOutput({tag, "_reg_write_src"}, 32'(reg_write_src), 32'd0);
      checkOutput({tag, "_instr_value"}, 32'(instr_value), 32'd0);
   endtask

   // Main sequence: reset, abort a store by reset, then walk through every opcode class.
   initial begin
      totalCount = 0;
      badCount   = 0;
      for (int i = 0; i < (1 << PW); i++) rom[i] = 32'h0;
      sys_rst_n  = 1'b1;
      vsync_tick = 1'b0;
      zero_flag  = 1'b0;
      result     = RESULT_VAL;
      operand1   = OPERAND1_VAL;
      tbPc       = '0;
      #1 sys_rst_n = 1'b0;
      #2;
      checkResetOutputs("rst");
      @(posedge sys_clock);
      #1 sys_rst_n = 1'b1;

      // Store aborted by reset during its EXECUTE cycle.
      applyStimulus(mkInstr(4'd4, 4'h0, 4'd2, 4'd0, 16'h0020), 1'b0, 1'b0, 0, 0);
      runCycles(2);
      #1;
      checkOutput("storeWeBeforeReset", 32'(data_mem_we), 32'd1);
      sys_rst_n = 1'b0;
      #1;
      checkResetOutputs("midRst");
      expQ.delete();
      tbPc = '0;
      @(posedge sys_clock);
      #1 sys_rst_n = 1'b1;

      // ALUI r1 = r0 + 5, then ALUR r2 = r1 + r1.
      doInstr(mkInstr(4'd2, 4'h0, 4'd1, 4'd0, 16'h0005), 1'b0, 1'b0, 0, 0);
      doInstr(mkInstr(4'd1, 4'h0, 4'd2, 4'd1, 16'h0001), 1'b0, 1'b0, 0, 0);
      // STORE r2 to [r0+0x20], then LOAD r3 from [r0+0x20].
      doInstr(mkInstr(4'd4, 4'h0, 4'd2, 4'd0, 16'h0020), 1'b0, 1'b0, 0, 0);
      doInstr(mkInstr(4'd3, 4'h0, 4'd3, 4'd0, 16'h0020), 1'b0, 1'b0, 0, 0);
      // Branches and jumps, including the top-of-ROM wrap.
      doInstr(mkInstr(4'd6, 4'h0, 4'd2, 4'd1, 16'h03F0), 1'b1, 1'b0, 0, 0);
      doInstr(mkInstr(4'd7, 4'h0, 4'd2, 4'd1, 16'h0010), 1'b1, 1'b0, 0, 0);
      doInstr(mkInstr(4'd8, 4'h0, 4'd0, 4'd0, 16'h03FF), 1'b0, 1'b0, 0, 0);
      doInstr(mkInstr(4'd8, 4'h0, 4'd0, 4'd0, 16'h03FE), 1'b0, 1'b0, 0, 0);
      doInstr(mkInstr(4'd8, 4'h0, 4'd0, 4'd0, 16'h03FF), 1'b0, 1'b0, 0, 0);
      doInstr(mkInstr(4'd0, 4'h0, 4'd0, 4'd0, 16'h0000), 1'b0, 1'b0, 0, 0);
      doInstr(mkInstr(4'd6, 4'h0, 4'd3, 4'd3, 16'h0000), 1'b1, 1'b0, 0, 0);
      // ALUI with a non-default op, then the two WAITV cases.
      doInstr(mkInstr(4'd2, 4'h7, 4'd5, 4'd6, 16'h1234), 1'b0, 1'b0, 0, 0);
      doInstr(mkInstr(4'd9, 4'h0, 4'd0, 4'd0, 16'h0000), 1'b0, 1'b1, 3, 0);
      doInstr(mkInstr(4'd9, 4'h0, 4'd0, 4'd0, 16'h0000), 1'b0, 1'b0, 1, 0);
      // Illegal opcode, RAND, taken BNE, untaken BEQ, then HALT.
      doInstr(mkInstr(4'hB, 4'h3, 4'd7, 4'd8, 16'h00A9), 1'b0, 1'b0, 0, 0);
      doInstr(mkInstr(4'd5, 4'h0, 4'd4, 4'd0, 16'h0000), 1'b0, 1'b0, 0, 0);
      doInstr(mkInstr(4'd7, 4'h0, 4'd1, 4'd2, 16'h0100), 1'b0, 1'b0, 0, 0);
      doInstr(mkInstr(4'd6, 4'h0, 4'd1, 4'd2, 16'h0200), 1'b0, 1'b0, 0, 0);
      doInstr(mkInstr(4'd15, 4'h0, 4'd0, 4'd0, 16'h0000), 1'b0, 1'b0, 0, 8);

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
